// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU operand bus: ID handshake, register-file data, pipeline
// forwarding sources and the registered EX-side operands.
interface alu_operand_stage_if #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 16,
   parameter int RA_W  = 5
);
   logic             id_valid;
   logic             id_ready;
   logic             flush;
   logic [RA_W-1:0]  rs;
   logic [RA_W-1:0]  rt;
   logic [WIDTH-1:0] read_d1;
   logic [WIDTH-1:0] read_d2;
   logic [IMM_W-1:0] imm;
   logic [1:0]       ALUsrc;

   logic             exmem_valid;
   logic             exmem_regwrite;
   logic             exmem_is_load;
   logic [RA_W-1:0]  exmem_rd;
   logic [WIDTH-1:0] exmem_data;
   logic             memwb_valid;
   logic             memwb_regwrite;
   logic [RA_W-1:0]  memwb_rd;
   logic [WIDTH-1:0] memwb_data;

   logic             ex_valid;
   logic             ex_ready;
   logic [WIDTH-1:0] ALUin1;
   logic [WIDTH-1:0] ALUin2;
   logic [WIDTH-1:0] store_data;

   modport master (
      output id_valid, flush, rs, rt, read_d1, read_d2, imm, ALUsrc,
      output exmem_valid, exmem_regwrite, exmem_is_load, exmem_rd, exmem_data,
      output memwb_valid, memwb_regwrite, memwb_rd, memwb_data,
      output ex_ready,
      input  id_ready, ex_valid, ALUin1, ALUin2, store_data
   );

   modport slave (
      input  id_valid, flush, rs, rt, read_d1, read_d2, imm, ALUsrc,
      input  exmem_valid, exmem_regwrite, exmem_is_load, exmem_rd, exmem_data,
      input  memwb_valid, memwb_regwrite, memwb_rd, memwb_data,
      input  ex_ready,
      output id_ready, ex_valid, ALUin1, ALUin2, store_data
   );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand-select register: forwarding, immediate extension, load-use stall.
// Forwarding and hazard detection are built only when ALU_OPERAND_FWD_EN is defined.
module alu_operand_stage #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 16,
   parameter int RA_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_operand_stage_if.slave bus
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load_en;
   logic             w_hazard;
   logic [WIDTH-1:0] w_fwd_a;
   logic [WIDTH-1:0] w_fwd_b;
   logic [WIDTH-1:0] w_imm_sext;
   logic [WIDTH-1:0] w_imm_zext;
   logic [WIDTH-1:0] w_imm_upper;
   logic [WIDTH-1:0] w_opb;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [WIDTH-1:0] r_store;

`ifdef ALU_OPERAND_FWD_EN
   logic w_exmem_fwd_ok;
   logic w_memwb_fwd_ok;

   // A load in EX/MEM has no data yet, so it is excluded from forwarding
   assign w_exmem_fwd_ok = bus.exmem_valid & bus.exmem_regwrite & ~bus.exmem_is_load;
   assign w_memwb_fwd_ok = bus.memwb_valid & bus.memwb_regwrite;

   always_comb begin
      w_fwd_a = bus.read_d1;
      if (bus.rs != '0) begin
         if (w_exmem_fwd_ok && (bus.exmem_rd == bus.rs))
            w_fwd_a = bus.exmem_data;
         else if (w_memwb_fwd_ok && (bus.memwb_rd == bus.rs))
            w_fwd_a = bus.memwb_data;
      end
   end

   always_comb begin
      w_fwd_b = bus.read_d2;
      if (bus.rt != '0) begin
         if (w_exmem_fwd_ok && (bus.exmem_rd == bus.rt))
            w_fwd_b = bus.exmem_data;
         else if (w_memwb_fwd_ok && (bus.memwb_rd == bus.rt))
            w_fwd_b = bus.memwb_data;
      end
   end

   assign w_hazard = bus.id_valid & bus.exmem_valid & bus.exmem_regwrite &
                     bus.exmem_is_load & (bus.exmem_rd != '0) &
                     ((bus.exmem_rd == bus.rs) | (bus.exmem_rd == bus.rt));
`else
   logic w_unused_fwd;

   assign w_fwd_a  = bus.read_d1;
   assign w_fwd_b  = bus.read_d2;
   assign w_hazard = 1'b0;
   assign w_unused_fwd = ^{bus.exmem_valid, bus.exmem_regwrite, bus.exmem_is_load,
                           bus.exmem_rd, bus.exmem_data, bus.memwb_valid,
                           bus.memwb_regwrite, bus.memwb_rd, bus.memwb_data};
`endif

   // Size casts avoid zero-width replications when WIDTH == IMM_W
   assign w_imm_sext  = WIDTH'($signed(bus.imm));
   assign w_imm_zext  = WIDTH'(bus.imm);
   assign w_imm_upper = w_imm_zext << (WIDTH - IMM_W);

   always_comb begin
      w_opb = w_fwd_b;
      unique case (bus.ALUsrc)
         2'd0:    w_opb = w_fwd_b;
         2'd1:    w_opb = w_imm_sext;
         2'd2:    w_opb = w_imm_zext;
         2'd3:    w_opb = w_imm_upper;
         default: w_opb = w_fwd_b;
      endcase
   end

   assign bus.id_ready = ((r_state == S_EMPTY) | bus.ex_ready) & ~w_hazard;
   assign bus.ex_valid = (r_state == S_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   // Flush outranks a same-cycle accept; a load while full is a pass-through
   always_comb begin
      w_state_nxt = r_state;
      w_load_en   = 1'b0;
      if (bus.flush) begin
         w_state_nxt = S_EMPTY;
      end else if (bus.id_valid && bus.id_ready) begin
         w_state_nxt = S_FULL;
         w_load_en   = 1'b1;
      end else if (bus.ex_ready && (r_state == S_FULL)) begin
         w_state_nxt = S_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a <= '0;
         r_alu_b <= '0;
         r_store <= '0;
      end else if (w_load_en) begin
         r_alu_a <= w_fwd_a;
         r_alu_b <= w_opb;
         r_store <= w_fwd_b;
      end
   end

   assign bus.ALUin1     = r_alu_a;
   assign bus.ALUin2     = r_alu_b;
   assign bus.store_data = r_store;

endmodule
